// File: rtl/prot_relay_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : prot_relay_if
//  Description : Bundles the comparator inputs, the operator clear button and
//                the relay / LED outputs of the protection relay sequencer.
//                master : the side that drives the comparator inputs and the
//                         clear button and observes the relay and LEDs.
//                slave  : the sequencer itself.
//  Signals     : vin_too_high     comparator, 1 = over-voltage (async)
//                vin_not_negative comparator, 0 = negative input (async)
//                lockout_clear    operator clear button, active high (async)
//                prot_relay_en    relay drive, 1 = closed
//                ok_led_en        lit while the relay is closed
//                fault_led_en     fault indicator (blinks in lockout)
//                vhi_led_en       latched over-voltage cause
//                vlo_led_en       latched negative-input cause
//                locked_out       1 while locked out
//  Revision    : 1.0  initial release
// ============================================================================
interface prot_relay_if;
  logic vin_too_high;
  logic vin_not_negative;
  logic lockout_clear;
  logic prot_relay_en;
  logic ok_led_en;
  logic fault_led_en;
  logic vhi_led_en;
  logic vlo_led_en;
  logic locked_out;

  modport master (
    output vin_too_high,
    output vin_not_negative,
    output lockout_clear,
    input  prot_relay_en,
    input  ok_led_en,
    input  fault_led_en,
    input  vhi_led_en,
    input  vlo_led_en,
    input  locked_out
  );

  modport slave (
    input  vin_too_high,
    input  vin_not_negative,
    input  lockout_clear,
    output prot_relay_en,
    output ok_led_en,
    output fault_led_en,
    output vhi_led_en,
    output vlo_led_en,
    output locked_out
  );
endinterface
`default_nettype wire

// File: rtl/prot_relay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : prot_relay_sequencer
//  Description : Protection relay sequencer driven by the window comparators.
//                Closes the relay only after a sustained run of good input,
//                drops it quickly on a fault, latches the fault cause, waits a
//                hold-off before re-arming and locks out after repeated
//                faults until the operator clears it.
//  Ports       : clk       slow system clock (divided LFOSC)
//                por_done  asynchronous active-low reset (low = reset)
//                bus       prot_relay_if.slave: comparator inputs, clear
//                          button, relay and LED outputs
//  Revision    : 1.0  initial release
// ============================================================================
module prot_relay_sequencer #(
  parameter int ARM_CYCLES     = 8,
  parameter int HOLDOFF_CYCLES = 54,
  parameter int MAX_RETRIES    = 3,
  parameter int STABLE_CYCLES  = 108,
  parameter int BLINK_CYCLES   = 27,
  parameter int CNT_WIDTH      = 8
) (
  input  wire logic   clk,
  input  wire logic   por_done,
  prot_relay_if.slave bus
);

  localparam int c_retry_w = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [1:0] c_arming  = 2'd0;
  localparam logic [1:0] c_on      = 2'd1;
  localparam logic [1:0] c_holdoff = 2'd2;
  localparam logic [1:0] c_lockout = 2'd3;

  localparam logic [CNT_WIDTH-1:0] c_timer_one  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_arm_last   = CNT_WIDTH'(ARM_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_hold_last  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_blink_last = CNT_WIDTH'(BLINK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_stable     = CNT_WIDTH'(STABLE_CYCLES);

  localparam logic [c_retry_w-1:0] c_retry_one = c_retry_w'(1);
  localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRIES);
  localparam logic [c_retry_w-1:0] c_retry_sat = {c_retry_w{1'b1}};

  // Two-flop synchronisers for the asynchronous inputs
  logic r_th_s1, r_th_s2;
  logic r_nn_s1, r_nn_s2;
  logic r_clr_s1, r_clr_s2, r_clr_d;

  // Sequencer state
  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_timer;
  logic [c_retry_w-1:0] r_retry;

  // Output flops
  logic r_relay;
  logic r_ok;
  logic r_fault_led;
  logic r_vhi;
  logic r_vlo;
  logic r_locked;

  // Next-state values
  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] w_timer_nxt;
  logic [c_retry_w-1:0] w_retry_nxt;
  logic                 w_fault_nxt;
  logic                 w_vhi_nxt;
  logic                 w_vlo_nxt;

  logic                 w_good;
  logic                 w_clear_rise;
  logic [CNT_WIDTH-1:0] w_timer_inc;
  logic [c_retry_w-1:0] w_retry_inc;

  assign w_good       = r_nn_s2 & ~r_th_s2;
  assign w_clear_rise = r_clr_s2 & ~r_clr_d;
  assign w_timer_inc  = r_timer + c_timer_one;
  // Saturating so a wide retry counter never wraps back to zero
  assign w_retry_inc  = (r_retry == c_retry_sat) ? r_retry : r_retry + c_retry_one;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry;
    w_fault_nxt = r_fault_led;
    w_vhi_nxt   = r_vhi;
    w_vlo_nxt   = r_vlo;

    case (r_state)
      c_arming: begin
        w_fault_nxt = 1'b0;
        if (!w_good) begin
          w_timer_nxt = '0;
        end else if (r_timer == c_arm_last) begin
          // ARM_CYCLES-th consecutive good cycle: close the relay and
          // forget the previous fault cause
          w_state_nxt = c_on;
          w_timer_nxt = '0;
          w_vhi_nxt   = 1'b0;
          w_vlo_nxt   = 1'b0;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      c_on: begin
        // A fault takes priority over the stable-time retry clear
        if (!w_good) begin
          if (r_th_s2) w_vhi_nxt = 1'b1;
          if (!r_nn_s2) w_vlo_nxt = 1'b1;
          w_retry_nxt = w_retry_inc;
          w_fault_nxt = 1'b1;
          w_timer_nxt = '0;
          if ((MAX_RETRIES != 0) && (w_retry_inc == c_retry_max)) begin
            w_state_nxt = c_lockout;
          end else begin
            w_state_nxt = c_holdoff;
          end
        end else if (r_timer != c_stable) begin
          w_timer_nxt = w_timer_inc;
          if (w_timer_inc == c_stable) begin
            w_retry_nxt = '0;
          end
        end
      end

      c_holdoff: begin
        // Input quality is irrelevant during the dwell
        if (r_timer == c_hold_last) begin
          w_state_nxt = c_arming;
          w_timer_nxt = '0;
          w_fault_nxt = 1'b0;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      c_lockout: begin
        if (w_clear_rise) begin
          w_state_nxt = c_arming;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
          w_vhi_nxt   = 1'b0;
          w_vlo_nxt   = 1'b0;
          w_fault_nxt = 1'b0;
        end else if (r_timer == c_blink_last) begin
          w_fault_nxt = ~r_fault_led;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      default: begin
        w_state_nxt = c_arming;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge por_done) begin
    if (!por_done) begin
      r_th_s1     <= 1'b0;
      r_th_s2     <= 1'b0;
      r_nn_s1     <= 1'b0;
      r_nn_s2     <= 1'b0;
      r_clr_s1    <= 1'b0;
      r_clr_s2    <= 1'b0;
      r_clr_d     <= 1'b0;
      r_state     <= c_arming;
      r_timer     <= '0;
      r_retry     <= '0;
      r_relay     <= 1'b0;
      r_ok        <= 1'b0;
      r_fault_led <= 1'b0;
      r_vhi       <= 1'b0;
      r_vlo       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_th_s1     <= bus.vin_too_high;
      r_th_s2     <= r_th_s1;
      r_nn_s1     <= bus.vin_not_negative;
      r_nn_s2     <= r_nn_s1;
      r_clr_s1    <= bus.lockout_clear;
      r_clr_s2    <= r_clr_s1;
      r_clr_d     <= r_clr_s2;
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry     <= w_retry_nxt;
      // Pin drivers are decoded from the next state so they change on the
      // same edge as the state and reach the pins straight from a flop
      r_relay     <= (w_state_nxt == c_on);
      r_ok        <= (w_state_nxt == c_on);
      r_locked    <= (w_state_nxt == c_lockout);
      r_fault_led <= w_fault_nxt;
      r_vhi       <= w_vhi_nxt;
      r_vlo       <= w_vlo_nxt;
    end
  end

  assign bus.prot_relay_en = r_relay;
  assign bus.ok_led_en     = r_ok;
  assign bus.fault_led_en  = r_fault_led;
  assign bus.vhi_led_en    = r_vhi;
  assign bus.vlo_led_en    = r_vlo;
  assign bus.locked_out    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_prot_relay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prot_relay_sequencer
//  Description : Self-checking bench for prot_relay_sequencer. Output vector
//                order everywhere: {relay, ok, fault_led, vhi, vlo, locked}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prot_relay_sequencer;
  localparam int ARM    = 8;
  localparam int HOLD   = 54;
  localparam int MAXR   = 3;
  localparam int STABLE = 108;
  localparam int BLINK  = 27;
  localparam int RCAP   = (1 << ((MAXR < 2) ? 1 : $clog2(MAXR + 1))) - 1;

  logic clk = 1'b0;
  logic por_done;
  always #5 clk = ~clk;

  prot_relay_if bus();

  prot_relay_sequencer #(
    .ARM_CYCLES(ARM), .HOLDOFF_CYCLES(HOLD), .MAX_RETRIES(MAXR),
    .STABLE_CYCLES(STABLE), .BLINK_CYCLES(BLINK), .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .por_done(por_done),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural reference ----------------
  typedef enum {M_ARM, M_ON, M_HOLD, M_LOCK} mode_t;
  mode_t m_mode;
  int    m_good_run, m_hold_left, m_on_age, m_blink_age, m_retries;
  bit    m_vhi, m_vlo, m_led;
  // input history: d1 = previous edge, d2 = two edges ago, ...
  bit    th_d1, th_d2, nn_d1, nn_d2, cl_d1, cl_d2, cl_d3;

  task automatic model_reset();
    m_mode = M_ARM; m_good_run = 0; m_hold_left = 0; m_on_age = 0;
    m_blink_age = 0; m_retries = 0; m_vhi = 0; m_vlo = 0; m_led = 0;
    th_d1 = 0; th_d2 = 0; nn_d1 = 0; nn_d2 = 0; cl_d1 = 0; cl_d2 = 0; cl_d3 = 0;
  endtask

  // One clock edge; the controller reacts to inputs two edges old
  task automatic model_step(input bit th, input bit nn, input bit cl);
    bit sth, snn, g, rise;
    sth  = th_d2;
    snn  = nn_d2;
    g    = snn && !sth;
    rise = cl_d2 && !cl_d3;
    case (m_mode)
      M_ARM: begin
        m_led = 0;
        if (g) begin
          m_good_run++;
          if (m_good_run == ARM) begin
            m_mode = M_ON; m_on_age = 0; m_vhi = 0; m_vlo = 0;
          end
        end else m_good_run = 0;
      end
      M_ON: begin
        if (!g) begin
          if (sth) m_vhi = 1;
          if (!snn) m_vlo = 1;
          if (m_retries < RCAP) m_retries++;
          m_led = 1;
          if (MAXR != 0 && m_retries == MAXR) begin
            m_mode = M_LOCK; m_blink_age = 0;
          end else begin
            m_mode = M_HOLD; m_hold_left = HOLD;
          end
        end else if (m_on_age < STABLE) begin
          m_on_age++;
          if (m_on_age == STABLE) m_retries = 0;
        end
      end
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_mode = M_ARM; m_good_run = 0; m_led = 0;
        end
      end
      M_LOCK: begin
        if (rise) begin
          m_mode = M_ARM; m_good_run = 0; m_retries = 0;
          m_vhi = 0; m_vlo = 0; m_led = 0;
        end else begin
          m_blink_age++;
          if (m_blink_age == BLINK) begin
            m_led = !m_led; m_blink_age = 0;
          end
        end
      end
      default: m_mode = M_ARM;
    endcase
    th_d2 = th_d1; th_d1 = th;
    nn_d2 = nn_d1; nn_d1 = nn;
    cl_d3 = cl_d2; cl_d2 = cl_d1; cl_d1 = cl;
  endtask

  function automatic logic [5:0] model_out();
    return {m_mode == M_ON, m_mode == M_ON, m_led, m_vhi, m_vlo, m_mode == M_LOCK};
  endfunction

  function automatic logic [5:0] dut_out();
    return {bus.prot_relay_en, bus.ok_led_en, bus.fault_led_en,
            bus.vhi_led_en, bus.vlo_led_en, bus.locked_out};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives inputs, advances one edge, checks the model
  // and optionally a hand-derived expectation.
  task automatic tick(input bit th, input bit nn, input bit cl,
                      input string tag, input bit use_exp, input logic [5:0] exp);
    bus.vin_too_high     = th;
    bus.vin_not_negative = nn;
    bus.lockout_clear    = cl;
    @(posedge clk);
    model_step(th, nn, cl);
    #1;
    check({tag, "/model"}, dut_out(), model_out());
    if (use_exp) check(tag, dut_out(), exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    por_done = 1'b0;
    bus.vin_too_high = 1'b0; bus.vin_not_negative = 1'b1; bus.lockout_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_out(), 6'b000000);
    por_done = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         th;
    bit         nn;
    bit         cl;
    int         cyc;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit th, input bit nn, input bit cl, input int cyc,
                     input logic [5:0] exp);
    vec_t v;
    v.th = th; v.nn = nn; v.cl = cl; v.cyc = cyc; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    por_done = 1'b0;
    bus.vin_too_high = 1'b0; bus.vin_not_negative = 1'b1; bus.lockout_clear = 1'b0;

    // arm, over-voltage fault, re-arm, double-cause fault, lockout, clear
    add(0,1,0, 9, 6'b000000);
    add(0,1,0, 1, 6'b110000);   // closes on the 10th clock
    add(0,1,0,20, 6'b110000);
    add(1,1,0, 2, 6'b110000);   // fault still in the synchronisers
    add(1,1,0, 1, 6'b001100);   // third clock: relay open, vhi latched
    add(0,1,0,53, 6'b001100);
    add(0,1,0, 1, 6'b000100);   // hold-off over, re-arming
    add(0,1,0, 7, 6'b000100);
    add(0,1,0, 1, 6'b110000);   // 54+8 after the fault; vhi cleared
    add(0,1,0,10, 6'b110000);
    add(1,0,0, 2, 6'b110000);
    add(1,0,0, 1, 6'b001110);   // both causes latched
    add(0,1,0,53, 6'b001110);
    add(0,1,0, 1, 6'b000110);
    add(0,1,0, 7, 6'b000110);
    add(0,1,0, 1, 6'b110000);
    add(0,0,0, 2, 6'b110000);
    add(0,0,0, 1, 6'b001011);   // third quick fault: lockout
    add(0,1,0,26, 6'b001011);
    add(0,1,0, 1, 6'b000011);   // blink toggles after 27
    add(0,1,0,26, 6'b000011);
    add(0,1,0, 1, 6'b001011);
    add(0,1,1, 1, 6'b001011);   // clear pulse
    add(0,1,0, 1, 6'b001011);
    add(0,1,0, 1, 6'b000000);   // clear edge reaches the controller
    add(0,1,0, 7, 6'b000000);
    add(0,1,0, 1, 6'b110000);

    repeat (2) @(posedge clk);
    do_reset();
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cyc; c++)
        tick(tbl[i].th, tbl[i].nn, tbl[i].cl, $sformatf("tbl%0d", i), 1'b1, tbl[i].exp);
    end

    // glitch at arm count 5 restarts arming
    do_reset();
    for (int e = 1; e <= 20; e++)
      tick(1'b0, (e != 6), 1'b0, $sformatf("glitch_e%0d", e), 1'b1,
           (e >= 16) ? 6'b110000 : 6'b000000);

    // asynchronous reset while ON, no clock edge in between
    #2;
    por_done = 1'b0;
    #1;
    check("async_reset", dut_out(), 6'b000000);
    @(posedge clk); #1;
    model_reset();
    por_done = 1'b1;

    // fault followed by long ON periods must never lock out
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, "stab_arm", 1'b0, 6'b0);
    for (int r = 0; r < 5; r++) begin
      tick(1'b1, 1'b1, 1'b0, "stab_fault", 1'b0, 6'b0);
      for (int i = 0; i < 180; i++) begin
        tick(1'b0, 1'b1, 1'b0, "stab_run", 1'b0, 6'b0);
        check("stab_nolock", {5'b0, bus.locked_out}, 6'b000000);
      end
    end
    check("stab_on", dut_out(), 6'b110000);

    // randomized segments against the reference
    do_reset();
    for (int s = 0; s < 45; s++) begin
      int glen, flen, kind;
      glen = $urandom_range(1, 140);
      flen = $urandom_range(1, 4);
      kind = $urandom_range(0, 2);
      for (int i = 0; i < glen; i++)
        tick(1'b0, 1'b1, ($urandom_range(0, 49) == 0), "rand_good", 1'b0, 6'b0);
      for (int i = 0; i < flen; i++)
        tick(kind != 1, kind == 0, 1'b0, "rand_fault", 1'b0, 6'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
